// File: rtl/cga_attrib_if.sv
// Pixel/attribute bus into cga_attrib and the registered colour result out.
//   master: pixel pipeline side, drives mode/attribute/pixel inputs, reads colour
//   slave : cga_attrib side, reads inputs, drives pix_out/overscan
interface cga_attrib_if;
  logic [7:0] att_byte;
  logic [4:0] row_addr;
  logic [7:0] cga_color_reg;
  logic       grph_mode;
  logic       bw_mode;
  logic       mode_640;
  logic       tandy_16_mode;
  logic       display_enable;
  logic       blink_enabled;
  logic       blink;
  logic       cursor;
  logic       hsync;
  logic       vsync;
  logic       pix_in;
  logic       c0;
  logic       c1;
  logic       pix_640;
  logic [3:0] pix_tandy;
  logic [3:0] tandy_bordercol;
  logic       tandy_color_4;
  logic       tandy_color_16;
  logic [3:0] pix_out;
  logic       overscan;

  modport master (
    output att_byte, row_addr, cga_color_reg, grph_mode, bw_mode, mode_640,
           tandy_16_mode, display_enable, blink_enabled, blink, cursor, hsync,
           vsync, pix_in, c0, c1, pix_640, pix_tandy, tandy_bordercol,
           tandy_color_4, tandy_color_16,
    input  pix_out, overscan
  );

  modport slave (
    input  att_byte, row_addr, cga_color_reg, grph_mode, bw_mode, mode_640,
           tandy_16_mode, display_enable, blink_enabled, blink, cursor, hsync,
           vsync, pix_in, c0, c1, pix_640, pix_tandy, tandy_bordercol,
           tandy_color_4, tandy_color_16,
    output pix_out, overscan
  );
endinterface

// File: rtl/cga_attrib.sv
// Final colour stage of the CGA/Tandy pixel pipeline: picks the IRGB colour
// index for the current pixel from sync, border, text attribute or graphics
// pixel bits, and registers it with an overscan flag for the Tandy palette.
// Ports:
//   clk   - pixel clock
//   reset - asynchronous active-high reset (outputs forced to 0)
//   bus   - cga_attrib_if.slave: attribute/mode/pixel inputs, pix_out/overscan out
module cga_attrib (
  input  logic          clk,
  input  logic          reset,
  cga_attrib_if.slave   bus
);

  localparam int unsigned ColW = 4;

  logic [ColW-1:0] pix_d, pix_q;
  logic            ovs_d, ovs_q;
  logic [ColW-1:0] fg_c, bg_c;
  logic            fg_sel_c;

  // Row address and the Tandy hi-res flag are carried for compatibility only.
  logic unused_ok;
  assign unused_ok = ^{bus.row_addr, bus.tandy_16_mode};

  // Text foreground/background and whether this glyph pixel shows foreground.
  always_comb begin
    fg_c     = bus.att_byte[3:0];
    bg_c     = bus.blink_enabled ? {1'b0, bus.att_byte[6:4]} : bus.att_byte[7:4];
    fg_sel_c = bus.pix_in;
    if (bus.blink_enabled && bus.att_byte[7] && bus.blink) begin
      fg_sel_c = 1'b0;
    end
    // Visible cursor overrides both the glyph and blink suppression.
    if (bus.cursor && !bus.blink) begin
      fg_sel_c = 1'b1;
    end
  end

  // Priority colour selection; earlier conditions win.
  always_comb begin
    pix_d = '0;
    ovs_d = 1'b0;
    if (bus.hsync || bus.vsync) begin
      ovs_d = 1'b1;
    end else if (!bus.display_enable) begin
      ovs_d = 1'b1;
      if (bus.tandy_color_4 || bus.tandy_color_16) begin
        pix_d = bus.tandy_bordercol;
      end else if (bus.grph_mode && bus.mode_640) begin
        pix_d = '0;
      end else begin
        pix_d = bus.cga_color_reg[3:0];
      end
    end else if (!bus.grph_mode) begin
      pix_d = fg_sel_c ? fg_c : bg_c;
    end else if (bus.tandy_color_16) begin
      pix_d = bus.pix_tandy;
    end else if (bus.tandy_color_4) begin
      // Colour index lands in bits [2:1] for the downstream palette.
      pix_d = {1'b0, bus.c1, bus.c0, 1'b0};
    end else if (bus.mode_640) begin
      pix_d = bus.pix_640 ? bus.cga_color_reg[3:0] : 4'h0;
    end else if ({bus.c1, bus.c0} == 2'b00) begin
      pix_d = bus.cga_color_reg[3:0];
    end else begin
      pix_d = {bus.cga_color_reg[4], bus.c1, bus.c0,
               bus.bw_mode ? bus.c0 : bus.cga_color_reg[5]};
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q <= '0;
      ovs_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      ovs_q <= ovs_d;
    end
  end

  assign bus.pix_out  = pix_q;
  assign bus.overscan = ovs_q;

endmodule

// File: tb/tb_cga_attrib.sv
// Bench for cga_attrib: directed literal checks plus randomized traffic
// compared every cycle against a rule-level model of the colour selection.
module tb_cga_attrib;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;
  logic [3:0] exp_pix;
  logic       exp_ovs;

  cga_attrib_if bus ();

  cga_attrib dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overscan, colour} from the current inputs.
  function automatic logic [4:0] model();
    int idx, col;
    bit tandy, show_fg;
    logic [3:0] fg, bg;
    tandy = bus.tandy_color_4 || bus.tandy_color_16;
    if (bus.hsync || bus.vsync) return 5'h10;
    if (!bus.display_enable) begin
      if (tandy) return {1'b1, bus.tandy_bordercol};
      if (bus.grph_mode && bus.mode_640) return 5'h10;
      return {1'b1, bus.cga_color_reg[3:0]};
    end
    if (!bus.grph_mode) begin
      fg = bus.att_byte[3:0];
      bg = bus.att_byte[7:4];
      if (bus.blink_enabled) bg[3] = 1'b0;
      if (bus.cursor && !bus.blink) show_fg = 1'b1;
      else if (bus.blink_enabled && bus.att_byte[7] && bus.blink) show_fg = 1'b0;
      else show_fg = bus.pix_in;
      return {1'b0, show_fg ? fg : bg};
    end
    if (bus.tandy_color_16) return {1'b0, bus.pix_tandy};
    idx = 2 * int'(bus.c1) + int'(bus.c0);
    if (bus.tandy_color_4) return 5'(idx * 2);
    if (bus.mode_640) return bus.pix_640 ? {1'b0, bus.cga_color_reg[3:0]} : 5'h00;
    if (idx == 0) return {1'b0, bus.cga_color_reg[3:0]};
    col = 8 * int'(bus.cga_color_reg[4]) + 2 * idx
        + (bus.bw_mode ? int'(bus.c0) : int'(bus.cga_color_reg[5]));
    return 5'(col);
  endfunction

  // Expected registered outputs: one clock behind the inputs, zero in reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_pix <= 4'h0;
      exp_ovs <= 1'b0;
    end else begin
      {exp_ovs, exp_pix} <= model();
    end
  end

  task automatic cmp(input string name, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got ovs/pix=%b/%h want %b/%h at %0t",
               name, got[4], got[3:0], want[4], want[3:0], $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) cmp("model", {bus.overscan, bus.pix_out}, {exp_ovs, exp_pix});
  end

  // Wait for the registering edge and check a hand-computed value.
  task automatic check(input string name, input logic [3:0] pix, input logic ovs);
    @(posedge clk);
    #1;
    cmp(name, {bus.overscan, bus.pix_out}, {ovs, pix});
  endtask

  task automatic idle();
    bus.att_byte = 8'h00; bus.row_addr = 5'd0; bus.cga_color_reg = 8'h00;
    bus.grph_mode = 1'b0; bus.bw_mode = 1'b0; bus.mode_640 = 1'b0;
    bus.tandy_16_mode = 1'b0; bus.display_enable = 1'b1;
    bus.blink_enabled = 1'b0; bus.blink = 1'b0; bus.cursor = 1'b0;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.pix_in = 1'b0;
    bus.c0 = 1'b0; bus.c1 = 1'b0; bus.pix_640 = 1'b0;
    bus.pix_tandy = 4'h0; bus.tandy_bordercol = 4'h0;
    bus.tandy_color_4 = 1'b0; bus.tandy_color_16 = 1'b0;
  endtask

  initial begin
    logic [3:0] e320   [4];
    logic [3:0] e320bw [4];
    logic [1:0] ci;
    e320   = '{4'h1, 4'hB, 4'hD, 4'hF};
    e320bw = '{4'h1, 4'hB, 4'hC, 4'hF};
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    cmp("reset_state", {bus.overscan, bus.pix_out}, 5'h00);
    chk_en = 1'b1;
    @(negedge clk); reset = 1'b0;

    // Text, no blink: pix_in toggles between fg E and bg 1.
    bus.att_byte = 8'h1E;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.pix_in = 1'(i % 2);
      check("text_toggle", (i % 2) ? 4'hE : 4'h1, 1'b0);
    end

    // Text blink attribute 0x9E.
    @(negedge clk); bus.blink_enabled = 1'b1; bus.att_byte = 8'h9E;
    bus.pix_in = 1'b1; bus.blink = 1'b1;
    check("blink_off", 4'h1, 1'b0);
    @(negedge clk); bus.blink = 1'b0;
    check("blink_on", 4'hE, 1'b0);
    @(negedge clk); bus.cursor = 1'b1; bus.pix_in = 1'b0;
    check("cursor", 4'hE, 1'b0);

    // 320x200 palettes.
    @(negedge clk); idle(); bus.grph_mode = 1'b1; bus.cga_color_reg = 8'h31;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ci = 2'(i % 4);
      bus.bw_mode = (i >= 4);
      {bus.c1, bus.c0} = ci;
      check(i >= 4 ? "g320_bw" : "g320", i >= 4 ? e320bw[ci] : e320[ci], 1'b0);
    end

    // 640 mode, border, sync.
    @(negedge clk); idle(); bus.grph_mode = 1'b1; bus.mode_640 = 1'b1;
    bus.cga_color_reg = 8'h0A; bus.pix_640 = 1'b1;
    check("m640_on", 4'hA, 1'b0);
    @(negedge clk); bus.pix_640 = 1'b0;
    check("m640_off", 4'h0, 1'b0);
    @(negedge clk); bus.pix_640 = 1'b1; bus.display_enable = 1'b0;
    check("m640_border", 4'h0, 1'b1);
    @(negedge clk); bus.display_enable = 1'b1; bus.hsync = 1'b1;
    check("m640_hsync", 4'h0, 1'b1);

    // Tandy modes and borders.
    @(negedge clk); bus.hsync = 1'b0; bus.tandy_color_16 = 1'b1; bus.pix_tandy = 4'h7;
    check("tandy16", 4'h7, 1'b0);
    @(negedge clk); bus.tandy_color_4 = 1'b1;
    check("tandy16_wins", 4'h7, 1'b0);
    @(negedge clk); bus.tandy_color_16 = 1'b0; bus.c1 = 1'b1; bus.c0 = 1'b0;
    check("tandy4", 4'h4, 1'b0);
    @(negedge clk); bus.display_enable = 1'b0; bus.tandy_bordercol = 4'h5;
    check("tandy_border", 4'h5, 1'b1);
    @(negedge clk); idle(); bus.display_enable = 1'b0; bus.cga_color_reg = 8'h03;
    check("text_border", 4'h3, 1'b1);

    // Asynchronous reset mid-frame.
    @(negedge clk); idle(); bus.att_byte = 8'h0C; bus.pix_in = 1'b1;
    check("pre_reset", 4'hC, 1'b0);
    #2 reset = 1'b1;
    #1 cmp("async_reset", {bus.overscan, bus.pix_out}, 5'h00);
    @(negedge clk); reset = 1'b0;
    check("post_reset", 4'hC, 1'b0);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.att_byte = 8'($urandom); bus.row_addr = 5'($urandom);
      bus.cga_color_reg = 8'($urandom);
      bus.grph_mode = 1'($urandom); bus.bw_mode = 1'($urandom);
      bus.mode_640 = ($urandom_range(0, 3) == 0);
      bus.tandy_16_mode = 1'($urandom);
      bus.display_enable = ($urandom_range(0, 4) != 0);
      bus.blink_enabled = 1'($urandom); bus.blink = 1'($urandom);
      bus.cursor = ($urandom_range(0, 3) == 0);
      bus.hsync = ($urandom_range(0, 9) == 0);
      bus.vsync = ($urandom_range(0, 19) == 0);
      bus.pix_in = 1'($urandom); bus.c0 = 1'($urandom); bus.c1 = 1'($urandom);
      bus.pix_640 = 1'($urandom); bus.pix_tandy = 4'($urandom);
      bus.tandy_bordercol = 4'($urandom);
      bus.tandy_color_4 = ($urandom_range(0, 3) == 0);
      bus.tandy_color_16 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #3 reset = 1'b0;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
